// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbitration slice.
package display_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int VALUE_W  = DIGITS * NIBBLE_W;

  typedef enum logic {IDLE, SHOW} disp_state_t;

  // Position of the set bit in a one-hot vector of up to eight requesters.
  function automatic int unsigned onehot_index(input logic [7:0] onehot);
    onehot_index = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[i]) onehot_index = i;
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after the pointer wins,
// with the pointer position itself considered last.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic          any
);

  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    any    = |req;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Time-sliced round-robin owner selection for the four-digit display; the
// owner's value is shown live while it requests and frozen once it lets go.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HOLD_TICKS = 100_000_000
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [VALUE_W*NUM_REQ-1:0] value,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       active,
  output logic [NIBBLE_W-1:0]        data0,
  output logic [NIBBLE_W-1:0]        data1,
  output logic [NIBBLE_W-1:0]        data2,
  output logic [NIBBLE_W-1:0]        data3
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  disp_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [PTR_W-1:0]     pointer_reg, pointer_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic                 active_reg, active_next;
  logic [VALUE_W-1:0]   data_reg, data_next;

  logic [VALUE_W-1:0]   value_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   winner;
  logic                 any_req;
  logic [PTR_W-1:0]     win_idx;
  logic                 load_winner;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign value_arr[gi] = value[gi*VALUE_W +: VALUE_W];
  end

  // The pointer always names the last owner, so the owner is searched last:
  // another pending requester wins at expiry, otherwise the owner keeps it.
  rr_picker #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_picker (
    .req     (req),
    .pointer (pointer_reg),
    .winner  (winner),
    .any     (any_req)
  );

  assign win_idx = PTR_W'(onehot_index(8'(winner)));

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      pointer_reg <= PTR_INIT;
      grant_reg   <= '0;
      active_reg  <= 1'b0;
      data_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pointer_reg <= pointer_next;
      grant_reg   <= grant_next;
      active_reg  <= active_next;
      data_reg    <= data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pointer_next = pointer_reg;
    grant_next   = grant_reg;
    active_next  = active_reg;
    data_next    = data_reg;
    load_winner  = 1'b0;

    case (state_reg)
      IDLE: load_winner = any_req;
      SHOW: begin
        if (count_reg == CNT_LAST) begin
          load_winner = any_req;
          if (!any_req) begin
            state_next  = IDLE;
            count_next  = '0;
            grant_next  = '0;
            active_next = 1'b0;
            data_next   = '0;
          end
        end else begin
          count_next = count_reg + 1'b1;
          if (req[pointer_reg]) data_next = value_arr[pointer_reg];
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_winner) begin
      state_next   = SHOW;
      count_next   = '0;
      pointer_next = win_idx;
      grant_next   = winner;
      active_next  = 1'b1;
      data_next    = value_arr[win_idx];
    end
  end

  assign grant  = grant_reg;
  assign active = active_reg;
  assign data0  = data_reg[0*NIBBLE_W +: NIBBLE_W];
  assign data1  = data_reg[1*NIBBLE_W +: NIBBLE_W];
  assign data2  = data_reg[2*NIBBLE_W +: NIBBLE_W];
  assign data3  = data_reg[3*NIBBLE_W +: NIBBLE_W];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed vector table, HOLD_TICKS=1 sequence and
// randomized traffic against a cycle-level behavioural model.
module tb_display_arbiter;

  localparam int NREQ = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [3:0]  req_a, req_b;
  logic [63:0] value_a, value_b;
  logic [3:0]  grant_a, grant_b;
  logic        active_a, active_b;
  logic [3:0]  a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  display_arbiter #(.NUM_REQ(4), .HOLD_TICKS(4)) dut_a (
    .clock(clock), .clear(clear), .req(req_a), .value(value_a),
    .grant(grant_a), .active(active_a),
    .data0(a_d0), .data1(a_d1), .data2(a_d2), .data3(a_d3)
  );

  display_arbiter #(.NUM_REQ(4), .HOLD_TICKS(1)) dut_b (
    .clock(clock), .clear(clear), .req(req_b), .value(value_b),
    .grant(grant_b), .active(active_b),
    .data0(b_d0), .data1(b_d1), .data2(b_d2), .data3(b_d3)
  );

  // Behavioural model: owner plus the number of cycles of its window still to run.
  typedef struct {
    bit          busy;
    int          owner;
    int          left;
    int          last;
    logic [15:0] data;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, int hold, bit clr, logic [3:0] r, logic [63:0] v);
    mstate_t n;
    int pick;
    n = s;
    if (!clr) begin
      n.busy = 0; n.owner = 0; n.left = 0; n.last = NREQ - 1; n.data = 16'h0;
      return n;
    end
    if (s.busy && s.left > 1) begin
      n.left = s.left - 1;
      if (r[s.owner]) n.data = v[16*s.owner +: 16];
      return n;
    end
    // Decision point: other requesters in rotation order, then the last owner.
    pick = -1;
    for (int k = 1; k < NREQ; k++) begin
      if (pick < 0 && r[(s.last + k) % NREQ]) pick = (s.last + k) % NREQ;
    end
    if (pick < 0 && r[s.last]) pick = s.last;
    if (pick >= 0) begin
      n.busy = 1; n.owner = pick; n.last = pick; n.left = hold;
      n.data = v[16*pick +: 16];
    end else begin
      n.busy = 0; n.left = 0; n.data = 16'h0;
    end
    return n;
  endfunction

  function automatic logic [3:0] mgrant(mstate_t s);
    logic [3:0] g;
    g = 4'b0;
    if (s.busy) g[s.owner] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Inputs are already driven at a falling edge; advance one rising edge.
  task automatic step_cycle();
    @(posedge clock);
    ma = mstep(ma, 4, clear, req_a, value_a);
    mb = mstep(mb, 1, clear, req_b, value_b);
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_models();
    check("a_grant",  16'(grant_a),  16'(mgrant(ma)));
    check("a_active", 16'(active_a), 16'(ma.busy));
    check("a_data",   {a_d3, a_d2, a_d1, a_d0}, ma.data);
    check("b_grant",  16'(grant_b),  16'(mgrant(mb)));
    check("b_active", 16'(active_b), 16'(mb.busy));
    check("b_data",   {b_d3, b_d2, b_d1, b_d0}, mb.data);
  endtask

  typedef struct {
    bit          clr;
    logic [3:0]  r;
    logic [63:0] v;
    logic [3:0]  eg;
    bit          ea;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit clr, logic [3:0] r, logic [63:0] v,
                              logic [3:0] eg, bit ea, logic [15:0] ed);
    vec_t x;
    x.clr = clr; x.r = r; x.v = v; x.eg = eg; x.ea = ea; x.ed = ed;
    vecs.push_back(x);
  endfunction

  localparam logic [63:0] VR = 64'h4444_3333_2222_1111;

  initial begin
    int owner;
    logic [3:0] exp_b;

    clear = 1'b0; req_a = '0; req_b = '0; value_a = '0; value_b = '0;
    ma = mstep(ma, 4, 1'b0, 4'b0, 64'b0);
    mb = mstep(mb, 1, 1'b0, 4'b0, 64'b0);

    // Reset, then a single held request with a keep-at-expiry and a drop.
    add(0, 4'b0000, 64'h0, 4'b0000, 0, 16'h0);
    for (int i = 0; i < 5; i++) add(1, 4'b0001, 64'hBEEF, 4'b0001, 1, 16'hBEEF);
    for (int i = 0; i < 3; i++) add(1, 4'b0000, 64'hBEEF, 4'b0001, 1, 16'hBEEF);
    add(1, 4'b0000, 64'hBEEF, 4'b0000, 0, 16'h0);
    // Full rotation with all requesters pending.
    add(0, 4'b1111, VR, 4'b0000, 0, 16'h0);
    for (int g = 0; g < 17; g++) begin
      owner = (g / 4) % 4;
      add(1, 4'b1111, VR, 4'(1 << owner), 1, 16'(16'h1111 * (owner + 1)));
    end
    // Early drop freezes the last live value.
    add(0, 4'b0000, 64'h0, 4'b0000, 0, 16'h0);
    add(1, 4'b0001, 64'h1234, 4'b0001, 1, 16'h1234);
    add(1, 4'b0001, 64'h5678, 4'b0001, 1, 16'h5678);
    add(1, 4'b0000, 64'h9999, 4'b0001, 1, 16'h5678);
    add(1, 4'b0000, 64'h9999, 4'b0001, 1, 16'h5678);
    add(1, 4'b0000, 64'h9999, 4'b0000, 0, 16'h0);
    // No preemption by a later request.
    add(0, 4'b0000, VR, 4'b0000, 0, 16'h0);
    add(1, 4'b0010, VR, 4'b0010, 1, 16'h2222);
    for (int i = 0; i < 3; i++) add(1, 4'b1010, VR, 4'b0010, 1, 16'h2222);
    add(1, 4'b1010, VR, 4'b1000, 1, 16'h4444);
    // Reset in the middle of a window.
    add(0, 4'b0000, VR, 4'b0000, 0, 16'h0);
    add(1, 4'b1111, VR, 4'b0001, 1, 16'h1111);
    add(1, 4'b1111, VR, 4'b0001, 1, 16'h1111);
    add(0, 4'b1111, VR, 4'b0000, 0, 16'h0);
    add(1, 4'b1111, VR, 4'b0001, 1, 16'h1111);

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; req_a = vecs[i].r; value_a = vecs[i].v;
      step_cycle();
      $display("vec %0d clear=%0b req=%b -> grant=%b active=%0b data=%h",
               i, clear, req_a, grant_a, active_a, {a_d3, a_d2, a_d1, a_d0});
      check("vec_grant",  16'(grant_a),  16'(vecs[i].eg));
      check("vec_active", 16'(active_a), 16'(vecs[i].ea));
      check("vec_data",   {a_d3, a_d2, a_d1, a_d0}, vecs[i].ed);
    end

    // HOLD_TICKS=1: two requesters alternate every cycle.
    clear = 1'b0; req_b = 4'b0000;
    step_cycle();
    clear = 1'b1; req_b = 4'b0101; value_b = 64'h0000_CCCC_0000_AAAA;
    for (int k = 0; k < 6; k++) begin
      step_cycle();
      exp_b = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      $display("hold1 %0d req=%b -> grant=%b data=%h", k, req_b, grant_b, {b_d3, b_d2, b_d1, b_d0});
      check("hold1_grant", 16'(grant_b), 16'(exp_b));
      check("hold1_data",  {b_d3, b_d2, b_d1, b_d0}, (k % 2 == 0) ? 16'hAAAA : 16'hCCCC);
    end

    // Randomized traffic against the model on both instances.
    for (int k = 0; k < 400; k++) begin
      clear = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 2) == 0) req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      value_a = {$urandom, $urandom};
      value_b = {$urandom, $urandom};
      step_cycle();
      $display("rand %0d clear=%0b req_a=%b grant_a=%b req_b=%b grant_b=%b",
               k, clear, req_a, grant_a, req_b, grant_b);
      check_models();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
